// File: rtl/vs_bus_arbiter_if.sv
// Handshake and serial bus bundle between the SCI/SDI requesters, the arbiter
// and the decoder serial pins.
interface vs_bus_arbiter_if;
  logic        i_DREQ;
  logic        i_cmd_valid;
  logic [31:0] i_cmd_data;
  logic        o_cmd_ready;
  logic        i_dat_valid;
  logic [15:0] i_dat_data;
  logic        o_dat_ready;
  logic        o_XCS;
  logic        o_XDCS;
  logic        o_SCK;
  logic        o_SI;
  logic        o_busy;
  logic        o_cmd_done;

  // Arbiter side: takes requests and DREQ, drives ready and decoder pins.
  modport slave (
    input  i_DREQ, i_cmd_valid, i_cmd_data, i_dat_valid, i_dat_data,
    output o_cmd_ready, o_dat_ready, o_XCS, o_XDCS, o_SCK, o_SI,
    output o_busy, o_cmd_done
  );

  // Requester / decoder side: the mirror image of the arbiter view.
  modport master (
    output i_DREQ, i_cmd_valid, i_cmd_data, i_dat_valid, i_dat_data,
    input  o_cmd_ready, o_dat_ready, o_XCS, o_XDCS, o_SCK, o_SI,
    input  o_busy, o_cmd_done
  );
endinterface

// File: rtl/vs_bus_arbiter.sv
// Arbitrates between a 32-bit SCI command stream and a 16-bit SDI data stream
// and serialises the granted word MSB first onto a shared SCK/SI pair, with a
// separate active-low select for each frame type and a quiet gap after each
// frame.
module vs_bus_arbiter #(
  parameter int SCK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  vs_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SCI_SHIFT = 2'd1;
  localparam logic [1:0] SDI_SHIFT = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  localparam logic [8:0] HALF_LAST = 9'(SCK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * SCK_DIV - 1);

  logic [1:0]  state_q,   state_d;
  logic [31:0] shift_q,   shift_d;
  logic [4:0]  bitCnt_q,  bitCnt_d;
  logic [8:0]  divCnt_q,  divCnt_d;
  logic        sck_q,     sck_d;
  logic        xcs_q,     xcs_d;
  logic        xdcs_q,    xdcs_d;
  logic        cmdDone_q, cmdDone_d;
  logic        lastCmd_q, lastCmd_d;

  logic        grantCmd;
  logic        grantDat;
  logic        shifting;
  logic        lastBit;

  assign shifting = (state_q == SCI_SHIFT) || (state_q == SDI_SHIFT);
  assign lastBit  = (bitCnt_q == ((state_q == SCI_SHIFT) ? 5'd31 : 5'd15));

  // Grant only from IDLE with DREQ high; a command wins unless the previous
  // frame was also a command and data is waiting, which yields alternation.
  always_comb begin
    grantCmd = 1'b0;
    grantDat = 1'b0;
    if ((state_q == IDLE) && bus.i_DREQ) begin
      if (bus.i_cmd_valid && !(lastCmd_q && bus.i_dat_valid)) begin
        grantCmd = 1'b1;
      end else if (bus.i_dat_valid) begin
        grantDat = 1'b1;
      end
    end
  end

  // Frame sequencing: load on grant, toggle SCK every SCK_DIV cycles, shift on
  // each falling SCK, close the frame after the last high half and hold a gap.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    divCnt_d  = divCnt_q;
    sck_d     = sck_q;
    xcs_d     = xcs_q;
    xdcs_d    = xdcs_q;
    lastCmd_d = lastCmd_q;
    cmdDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantCmd) begin
          state_d   = SCI_SHIFT;
          shift_d   = bus.i_cmd_data;
          xcs_d     = 1'b0;
          bitCnt_d  = 5'd0;
          divCnt_d  = 9'd0;
          sck_d     = 1'b0;
          lastCmd_d = 1'b1;
        end else if (grantDat) begin
          state_d   = SDI_SHIFT;
          shift_d   = {bus.i_dat_data, 16'h0000};
          xdcs_d    = 1'b0;
          bitCnt_d  = 5'd0;
          divCnt_d  = 9'd0;
          sck_d     = 1'b0;
          lastCmd_d = 1'b0;
        end
      end
      SCI_SHIFT, SDI_SHIFT: begin
        if (divCnt_q == HALF_LAST) begin
          divCnt_d = 9'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (lastBit) begin
              state_d   = GAP;
              xcs_d     = 1'b1;
              xdcs_d    = 1'b1;
              cmdDone_d = (state_q == SCI_SHIFT);
            end else begin
              shift_d  = {shift_q[30:0], 1'b0};
              bitCnt_d = bitCnt_q + 5'd1;
            end
          end
        end else begin
          divCnt_d = divCnt_q + 9'd1;
        end
      end
      GAP: begin
        if (divCnt_q == GAP_LAST) begin
          state_d  = IDLE;
          divCnt_d = 9'd0;
        end else begin
          divCnt_d = divCnt_q + 9'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame and makes data the last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 32'h0;
      bitCnt_q  <= 5'd0;
      divCnt_q  <= 9'd0;
      sck_q     <= 1'b0;
      xcs_q     <= 1'b1;
      xdcs_q    <= 1'b1;
      cmdDone_q <= 1'b0;
      lastCmd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      divCnt_q  <= divCnt_d;
      sck_q     <= sck_d;
      xcs_q     <= xcs_d;
      xdcs_q    <= xdcs_d;
      cmdDone_q <= cmdDone_d;
      lastCmd_q <= lastCmd_d;
    end
  end

  assign bus.o_cmd_ready = grantCmd;
  assign bus.o_dat_ready = grantDat;
  assign bus.o_XCS       = xcs_q;
  assign bus.o_XDCS      = xdcs_q;
  assign bus.o_SCK       = sck_q;
  assign bus.o_SI        = shifting ? shift_q[31] : 1'b0;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_cmd_done  = cmdDone_q;

endmodule
